// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode that carries
// the PC, instruction word and branch prediction of each fetched instruction.
module fetch_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_inst,
    input  logic                     enq_is_branch,
    input  logic                     enq_pred_taken,
    input  logic [31:0]              enq_pred_target,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_pc,
    output logic [31:0]              deq_inst,
    output logic                     deq_is_branch,
    output logic                     deq_pred_taken,
    output logic [31:0]              deq_pred_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_branch;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head_entry;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            enq_fire;
    logic            deq_fire;

    assign enq_ready = (count != CW'(DEPTH));
    assign deq_valid = (count != '0);
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_valid && deq_ready && !flush;

    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire)
                tail <= tail + PW'(1);
            if (deq_fire)
                head <= head + PW'(1);
            count <= count + CW'(enq_fire) - CW'(deq_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire)
            mem[tail] <= '{pc: enq_pc, inst: enq_inst, is_branch: enq_is_branch,
                           pred_taken: enq_pred_taken, pred_target: enq_pred_target};
    end

    // An empty queue presents all-zero fields rather than stale storage.
    always_comb begin
        head_entry = '0;
        if (deq_valid)
            head_entry = mem[head];
    end

    assign deq_pc          = head_entry.pc;
    assign deq_inst        = head_entry.inst;
    assign deq_is_branch   = head_entry.is_branch;
    assign deq_pred_taken  = head_entry.pred_taken;
    assign deq_pred_target = head_entry.pred_target;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              enq_valid = 1'b0;
    logic              enq_ready;
    logic [31:0]       enq_pc = '0;
    logic [31:0]       enq_inst = '0;
    logic              enq_is_branch = 1'b0;
    logic              enq_pred_taken = 1'b0;
    logic [31:0]       enq_pred_target = '0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [31:0]       deq_pc;
    logic [31:0]       deq_inst;
    logic              deq_is_branch;
    logic              deq_pred_taken;
    logic [31:0]       deq_pred_target;
    logic [CW-1:0]     count;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    ent_t mq[$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_inst(enq_inst), .enq_is_branch(enq_is_branch),
        .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_is_branch(deq_is_branch),
        .deq_pred_taken(deq_pred_taken), .deq_pred_target(deq_pred_target),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference model advance: decide what the rules allow, take the edge, apply.
    task automatic tick();
        bit   ef;
        bit   df;
        ent_t e;
        ef = enq_valid && (mq.size() < DEPTH) && !flush;
        df = deq_ready && (mq.size() > 0) && !flush;
        e  = '{pc: enq_pc, inst: enq_inst, br: enq_is_branch, tk: enq_pred_taken, tgt: enq_pred_target};
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (df) void'(mq.pop_front());
            if (ef) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive_enq(input logic v, input logic [31:0] pc);
        enq_valid       = v;
        enq_pc          = pc;
        enq_inst        = $urandom;
        enq_is_branch   = 1'($urandom);
        enq_pred_taken  = 1'($urandom);
        enq_pred_target = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (count !== '0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d deq_valid=%b enq_ready=%b, want 0/0/1", count, deq_valid, enq_ready);
        end
        vectors++;
        if ({deq_pc, deq_inst, deq_pred_target, deq_is_branch, deq_pred_taken} !== '0) begin
            miscompares++;
            $display("FAIL reset_fields: pc=%h inst=%h tgt=%h, want 0", deq_pc, deq_inst, deq_pred_target);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
    endtask

    task automatic test_single();
        deq_ready       = 1'b0;
        enq_valid       = 1'b1;
        enq_pc          = 32'h8000_0000;
        enq_inst        = 32'h0800_0010;
        enq_is_branch   = 1'b1;
        enq_pred_taken  = 1'b1;
        enq_pred_target = 32'h8000_0040;
        tick();
        enq_valid = 1'b0;
        vectors++;
        if (deq_valid !== 1'b1 || count !== CW'(1)) begin
            miscompares++;
            $display("FAIL single_valid: deq_valid=%b count=%0d, want 1/1", deq_valid, count);
        end
        vectors++;
        if (deq_pc !== 32'h8000_0000 || deq_inst !== 32'h0800_0010 || deq_is_branch !== 1'b1 ||
            deq_pred_taken !== 1'b1 || deq_pred_target !== 32'h8000_0040) begin
            miscompares++;
            $display("FAIL single_fields: pc=%h inst=%h br=%b tk=%b tgt=%h, want 80000000/08000010/1/1/80000040",
                     deq_pc, deq_inst, deq_is_branch, deq_pred_taken, deq_pred_target);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        vectors++;
        if (count !== '0 || deq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drain: count=%0d deq_valid=%b, want 0/0", count, deq_valid);
        end
    endtask

    task automatic test_fill_drain();
        deq_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_enq(1'b1, 32'h8000_0000 + 32'(4 * k));
            tick();
        end
        vectors++;
        if (count !== CW'(8) || enq_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: count=%0d enq_ready=%b, want 8/0", count, enq_ready);
        end
        drive_enq(1'b1, 32'hDEAD_BEEF);
        tick();
        enq_valid = 1'b0;
        vectors++;
        if (count !== CW'(8) || deq_pc !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL fill_ninth_ignored: count=%0d head_pc=%h, want 8/80000000", count, deq_pc);
        end
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (deq_valid !== 1'b1 || deq_pc !== 32'h8000_0000 + 32'(4 * k) || deq_inst !== mq[0].inst ||
                deq_pred_target !== mq[0].tgt || deq_is_branch !== mq[0].br || deq_pred_taken !== mq[0].tk) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: pc=%h inst=%h, want %h/%h", k, deq_pc, deq_inst,
                         32'h8000_0000 + 32'(4 * k), mq[0].inst);
            end
            tick();
        end
        deq_ready = 1'b0;
        vectors++;
        if (count !== '0 || deq_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: count=%0d deq_valid=%b, want 0/0", count, deq_valid);
        end
    endtask

    task automatic test_back_to_back();
        deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive_enq(1'b1, 32'h9000_0000 + 32'(4 * k));
            if (k > 0) begin
                vectors++;
                if (deq_pc !== 32'h9000_0000 + 32'(4 * (k - 1)) || deq_inst !== mq[0].inst) begin
                    miscompares++;
                    $display("FAIL stream_order[%0d]: pc=%h, want %h", k, deq_pc, 32'h9000_0000 + 32'(4 * (k - 1)));
                end
            end
            tick();
            vectors++;
            if (count !== CW'(1)) begin
                miscompares++;
                $display("FAIL stream_count[%0d]: count=%0d, want 1", k, count);
            end
        end
        enq_valid = 1'b0;
        vectors++;
        if (deq_pc !== 32'h9000_004C) begin
            miscompares++;
            $display("FAIL stream_last: pc=%h, want 9000004c", deq_pc);
        end
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic test_full_simul();
        deq_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_enq(1'b1, 32'hA000_0000 + 32'(4 * k));
            tick();
        end
        drive_enq(1'b1, 32'hA000_1000);
        deq_ready = 1'b1;
        tick();
        vectors++;
        if (count !== CW'(7) || deq_pc !== 32'hA000_0004 || enq_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_deq: count=%0d head_pc=%h enq_ready=%b, want 7/a0000004/1", count, deq_pc, enq_ready);
        end
        deq_ready = 1'b0;
        tick();
        enq_valid = 1'b0;
        vectors++;
        if (count !== CW'(8)) begin
            miscompares++;
            $display("FAIL full_next_enq: count=%0d, want 8", count);
        end
        deq_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (deq_pc !== mq[0].pc || deq_pred_target !== mq[0].tgt) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: pc=%h tgt=%h, want %h/%h", k, deq_pc, deq_pred_target, mq[0].pc, mq[0].tgt);
            end
            if (k == 7) begin
                vectors++;
                if (deq_pc !== 32'hA000_1000) begin
                    miscompares++;
                    $display("FAIL full_late_entry: pc=%h, want a0001000", deq_pc);
                end
            end
            tick();
        end
        deq_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) begin
            drive_enq(1'b1, 32'hB000_0000 + 32'(4 * k));
            tick();
        end
        drive_enq(1'b1, 32'hB000_0100);
        deq_ready = 1'b1;
        flush     = 1'b1;
        vectors++;
        if (count !== CW'(5)) begin
            miscompares++;
            $display("FAIL flush_pre: count=%0d, want 5", count);
        end
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        vectors++;
        if (count !== '0 || deq_valid !== 1'b0 || deq_pc !== '0 || enq_ready !== 1'b1 || deq_inst !== '0) begin
            miscompares++;
            $display("FAIL flush_post: count=%0d deq_valid=%b pc=%h enq_ready=%b, want 0/0/0/1", count, deq_valid, deq_pc, enq_ready);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            drive_enq(1'b1, 32'hC000_0000 + 32'(4 * k));
            tick();
        end
        enq_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== '0 || deq_valid !== 1'b0 || deq_pc !== '0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d deq_valid=%b pc=%h, want 0/0/0", count, deq_valid, deq_pc);
        end
        mq.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_enq(1'b1, 32'hC000_1000);
        tick();
        enq_valid = 1'b0;
        vectors++;
        if (count !== CW'(1) || deq_pc !== 32'hC000_1000 || deq_inst !== mq[0].inst) begin
            miscompares++;
            $display("FAIL reset_first_entry: count=%0d pc=%h, want 1/c0001000", count, deq_pc);
        end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            drive_enq(($urandom % 4) != 0, $urandom);
            deq_ready = (($urandom % 3) != 0) || (n % 50 < 10 && n > 200);
            if (n % 50 >= 10 && n % 50 < 25) deq_ready = 1'b0;
            flush = (($urandom % 40) == 0);
            h = (mq.size() > 0) ? mq[0] : '{pc: '0, inst: '0, br: 1'b0, tk: 1'b0, tgt: '0};
            vectors++;
            if (count !== CW'(mq.size()) || deq_valid !== (mq.size() != 0) || enq_ready !== (mq.size() != DEPTH)) begin
                miscompares++;
                $display("FAIL rand_status[%0d]: count=%0d deq_valid=%b enq_ready=%b, want %0d/%b/%b", n, count,
                         deq_valid, enq_ready, mq.size(), mq.size() != 0, mq.size() != DEPTH);
            end
            vectors++;
            if (deq_pc !== h.pc || deq_inst !== h.inst || deq_is_branch !== h.br ||
                deq_pred_taken !== h.tk || deq_pred_target !== h.tgt) begin
                miscompares++;
                $display("FAIL rand_head[%0d]: pc=%h inst=%h br=%b tk=%b tgt=%h, want %h/%h/%b/%b/%h", n, deq_pc,
                         deq_inst, deq_is_branch, deq_pred_taken, deq_pred_target, h.pc, h.inst, h.br, h.tk, h.tgt);
            end
            tick();
        end
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_full_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue capacity in entries; SHALL be a power of two and at least 2.
REQ-002 clk  input  1  single clock for all state; every register SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  discards all queued entries (pipeline redirect).
REQ-005 enq_valid  input  1  fetch stage presents an entry.
REQ-006 enq_ready  output  1  queue accepts an entry this cycle.
REQ-007 enq_pc  input  32  PC of the fetched instruction.
REQ-008 enq_inst  input  32  fetched instruction word.
REQ-009 enq_is_branch  input  1  predictor marked the instruction as a control transfer.
REQ-010 enq_pred_taken  input  1  predictor's taken decision.
REQ-011 enq_pred_target  input  32  predictor's target address.
REQ-012 deq_valid  output  1  head entry is valid for decode.
REQ-013 deq_ready  input  1  decode consumes the head entry this cycle.
REQ-014 deq_pc, deq_inst, deq_pred_target  output  32 each  head entry fields.
REQ-015 deq_is_branch, deq_pred_taken  output  1 each  head entry fields.
REQ-016 count  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries, each holding {pc, inst, is_branch, pred_taken, pred_target}, with head pointer, tail pointer and occupancy counter.
REQ-018 enq_ready SHALL equal (count != DEPTH) and SHALL NOT depend on deq_ready, enq_valid or flush.
REQ-019 Enqueue fires when enq_valid && enq_ready && !flush: write the entry at tail, and tail advances by 1, modulo DEPTH.
REQ-020 deq_valid SHALL equal (count != 0); deq_* fields SHALL be driven combinationally from the head entry.
REQ-021 When count == 0, all deq_* data fields SHALL be driven to 0.
REQ-022 Dequeue fires when deq_valid && deq_ready && !flush: head advances by 1, modulo DEPTH.
REQ-023 count next = count + enq_fire - deq_fire; simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-024 Latency: an entry enqueued on edge N SHALL appear on deq_* after edge N; the queue SHALL have no same-cycle bypass from enq to deq.
REQ-025 Ordering SHALL be strict FIFO; the field values of every entry SHALL be preserved bit-exactly.
REQ-026 Full (count == DEPTH) with deq_fire: the dequeue completes and count becomes DEPTH-1; enq_valid in that cycle is not accepted.
REQ-027 Empty (count == 0) with deq_ready high: no pointer or count change.
REQ-028 Pointer wrap: on an advance from index DEPTH-1, the pointer SHALL become 0 with no bubble.
REQ-029 flush has priority over enqueue and dequeue: on the next edge head=tail=0 and count=0; any same-cycle enq/deq is discarded.
REQ-030 Writes to storage SHALL occur only on enqueue fire.
REQ-031 Storage contents need no reset.

Reset
REQ-032 While rst_n is low, head, tail and count SHALL be 0 immediately, independent of clk.
REQ-033 After reset: deq_valid=0, enq_ready=1, count=0, all deq_* data fields=0.
REQ-034 Reset asserted mid-operation SHALL drop all entries; the first enqueue after deassertion SHALL be the first entry dequeued.

Verification
REQ-035 Reset, then enqueue pc=0x80000000, inst=0x08000010, is_branch=1, pred_taken=1, target=0x80000040, deq_ready=0 -> next cycle deq_valid=1, all fields match, count=1.
REQ-036 With deq_ready=0, enqueue 8 entries pc=0x80000000+4k -> count=8, enq_ready=0; a 9th enq_valid is ignored; then drain with deq_ready=1 -> PCs emerge in order 0x80000000..0x8000001C, with count=0 at the end.
REQ-037 Stream 20 entries with enq_valid=1 and deq_ready=1 each cycle -> count stays 1 after the first cycle, pointers wrap twice, and output order is intact.
REQ-038 Hold count=8 (full) with enq_valid=1 and deq_ready=1 -> the head dequeues, count=7, and the enqueue is accepted only in the following cycle.
REQ-039 Hold count=5, assert flush together with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, deq_pc=0, enq_ready=1.
REQ-040 Hold count=3, pulse rst_n low between clock edges -> count=0 and deq_valid=0 before the next rising edge.
